// File: rtl/prbs_pkg.sv
// Shared types and PRBS constants for the multi-channel symbol source.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MAX_ORDER = 31;

  // Bit i set means stage i+1 of the polynomial feeds the XOR; unsupported orders give 0.
  function automatic logic [MAX_ORDER-1:0] tap_mask(input int order);
    logic [MAX_ORDER-1:0] m;
    m = '0;
    case (order)
      7:       begin m[6]  = 1'b1; m[5]  = 1'b1; end
      9:       begin m[8]  = 1'b1; m[4]  = 1'b1; end
      15:      begin m[14] = 1'b1; m[13] = 1'b1; end
      23:      begin m[22] = 1'b1; m[17] = 1'b1; end
      31:      begin m[30] = 1'b1; m[27] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [MAX_ORDER-1:0] seed(input int order, input int k);
    logic [MAX_ORDER-1:0] ones;
    ones = '0;
    for (int i = 0; i < MAX_ORDER; i++) begin
      if (i < order) ones[i] = 1'b1;
    end
    return ones ^ MAX_ORDER'(k);
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Single Fibonacci LFSR channel; shifts left with feedback into bit 0 on each step.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int                    PRBS_ORDER = 9,
  parameter logic [PRBS_ORDER-1:0] SEED       = '1
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_step,
  output logic o_bit
);

  localparam logic [MAX_ORDER-1:0]  TAPS_FULL = tap_mask(PRBS_ORDER);
  localparam logic [PRBS_ORDER-1:0] TAPS      = TAPS_FULL[PRBS_ORDER-1:0];

  logic [PRBS_ORDER-1:0] lfsr_q;
  logic [PRBS_ORDER-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      lfsr_q <= SEED;
    end else if (i_step) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_bit = lfsr_q[PRBS_ORDER-1];

endmodule

// File: rtl/prbs_symbol_source.sv
// Multi-channel PRBS symbol source: rate divider, continuous/burst FSM and
// per-channel LFSRs stepped on the symbol strobe.
module prbs_symbol_source
  import prbs_pkg::*;
#(
  parameter int NB_DIV     = 4,
  parameter int N_CH       = 2,
  parameter int PRBS_ORDER = 9,
  parameter int NB_BURST   = 8,
  parameter int NB_SYMCNT  = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_burst_mode,
  input  logic                 i_start,
  input  logic [NB_DIV-1:0]    i_div,
  input  logic [NB_BURST-1:0]  i_burst_len,
  input  logic [N_CH-1:0]      i_ch_enable,
  output logic                 o_valid,
  output logic [N_CH-1:0]      o_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_SYMCNT-1:0] o_sym_count
);

  localparam logic [NB_BURST:0] BURST_FULL = {1'b1, {NB_BURST{1'b0}}};
  localparam logic [NB_BURST:0] BURST_LAST = (NB_BURST+1)'(1);

  state_e               state_q;
  logic [NB_DIV-1:0]    div_cnt_q;
  logic                 burst_mode_q;
  logic [NB_BURST:0]    remaining_q;
  logic                 valid_q;
  logic [N_CH-1:0]      data_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NB_SYMCNT-1:0] sym_count_q;

  logic                 strobe;
  logic [N_CH-1:0]      lfsr_bit;
  logic [N_CH-1:0]      data_d;
  logic [NB_SYMCNT-1:0] sym_count_d;
  logic [NB_BURST:0]    remaining_d;

  // Gating with i_enable keeps an abort cycle from also emitting a symbol.
  assign strobe      = (state_q == ST_RUN) && i_enable && (div_cnt_q == i_div);
  assign data_d      = lfsr_bit & i_ch_enable;
  assign sym_count_d = sym_count_q + NB_SYMCNT'(1);
  assign remaining_d = (i_burst_len == '0) ? BURST_FULL : {1'b0, i_burst_len};

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam logic [MAX_ORDER-1:0] SEED_FULL = seed(PRBS_ORDER, gi);

      prbs_lfsr #(
        .PRBS_ORDER (PRBS_ORDER),
        .SEED       (SEED_FULL[PRBS_ORDER-1:0])
      ) u_lfsr (
        .clock   (clock),
        .i_reset (i_reset),
        .i_step  (strobe & i_ch_enable[gi]),
        .o_bit   (lfsr_bit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      burst_mode_q <= 1'b0;
      remaining_q  <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sym_count_q  <= '0;
    end else begin
      valid_q <= strobe;
      if (strobe) begin
        data_q      <= data_d;
        sym_count_q <= sym_count_d;
      end

      case (state_q)
        ST_IDLE: begin
          div_cnt_q <= '0;
          done_q    <= 1'b0;
          if (i_enable && (!i_burst_mode || i_start)) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
            burst_mode_q <= i_burst_mode;
            remaining_q  <= remaining_d;
            if (i_burst_mode) sym_count_q <= '0;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            div_cnt_q <= '0;
          end else if (strobe) begin
            div_cnt_q   <= '0;
            remaining_q <= remaining_q - BURST_LAST;
            if (burst_mode_q && (remaining_q == BURST_LAST)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + NB_DIV'(1);
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          done_q    <= 1'b0;
          div_cnt_q <= '0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          div_cnt_q <= '0;
        end
      endcase
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_sym_count = sym_count_q;

endmodule

// File: tb/tb_prbs_symbol_source.sv
// Directed bench for prbs_symbol_source with an independent PRBS9 model feeding a scoreboard.
module tb_prbs_symbol_source;

  localparam int NB_DIV     = 4;
  localparam int N_CH       = 2;
  localparam int PRBS_ORDER = 9;
  localparam int NB_BURST   = 4;
  localparam int NB_SYMCNT  = 16;

  logic                 clock = 1'b0;
  logic                 i_reset;
  logic                 i_enable;
  logic                 i_burst_mode;
  logic                 i_start;
  logic [NB_DIV-1:0]    i_div;
  logic [NB_BURST-1:0]  i_burst_len;
  logic [N_CH-1:0]      i_ch_enable;
  logic                 o_valid;
  logic [N_CH-1:0]      o_data;
  logic                 o_busy;
  logic                 o_done;
  logic [NB_SYMCNT-1:0] o_sym_count;

  always #5 clock = ~clock;

  prbs_symbol_source #(
    .NB_DIV     (NB_DIV),
    .N_CH       (N_CH),
    .PRBS_ORDER (PRBS_ORDER),
    .NB_BURST   (NB_BURST),
    .NB_SYMCNT  (NB_SYMCNT)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_burst_mode (i_burst_mode),
    .i_start      (i_start),
    .i_div        (i_div),
    .i_burst_len  (i_burst_len),
    .i_ch_enable  (i_ch_enable),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_sym_count  (o_sym_count)
  );

  int checks = 0;
  int errors = 0;
  logic [N_CH-1:0] exp_q[$];
  logic [8:0]      model[N_CH];
  logic            rec0[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    model[0] = 9'h1FF;
    model[1] = 9'h1FE;
  endtask

  // Predict n symbols using the channel enables currently driven.
  task automatic push_exp(input int n);
    logic [N_CH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < N_CH; k++) begin
        if (i_ch_enable[k]) begin
          w[k]     = model[k][8];
          model[k] = {model[k][7:0], model[k][8] ^ model[k][4]};
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_valids(input int n, input int period, input int first_lat, input bit done_at_end);
    int got = 0;
    int cyc = 0;
    int last = 0;
    logic [N_CH-1:0] e;
    bit last_one;
    while (got < n) begin
      tick();
      cyc++;
      if (cyc > n * 20 + 40) begin
        check("timeout_valids", 32'(got), 32'(n));
        break;
      end
      if (o_valid) begin
        last_one = (got == n - 1) && done_at_end;
        if (got == 0 && first_lat > 0) check("first_latency", 32'(cyc), 32'(first_lat));
        if (got > 0 && period > 0) check("period", 32'(cyc - last), 32'(period));
        last = cyc;
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(o_data), 32'(e));
        end
        rec0.push_back(o_data[0]);
        check("done_at_valid", 32'(o_done), 32'(last_one));
        check("busy_at_valid", 32'(o_busy), 32'(!last_one));
        got++;
      end else begin
        check("no_done", 32'(o_done), 32'(0));
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'(0));
    check({tag, "_done"}, 32'(o_done), 32'(0));
    check({tag, "_busy"}, 32'(o_busy), 32'(0));
  endtask

  task automatic check_pattern(input string tag);
    logic [13:0] pat;
    pat = 14'b11111111100000;
    if (rec0.size() < 14) begin
      check({tag, "_len"}, 32'(rec0.size()), 32'(14));
    end else begin
      for (int i = 0; i < 14; i++) check(tag, 32'(rec0[i]), 32'(pat[13-i]));
    end
  endtask

  task automatic start_pulse();
    i_start  = 1'b1;
    i_enable = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_burst_mode = 1'b0; i_start = 1'b0;
    i_div = '0; i_burst_len = '0; i_ch_enable = 2'b01;
    model_reset();
    repeat (3) tick();
    check_quiet("reset");
    check("reset_data", 32'(o_data), 32'(0));
    check("reset_symcnt", 32'(o_sym_count), 32'(0));
    i_reset = 1'b1;
    tick();

    // Continuous, i_div=0: full period on channel 0
    rec0.delete();
    push_exp(520);
    i_enable = 1'b1;
    wait_valids(520, 1, 2, 1'b0);
    i_enable = 1'b0;
    check_pattern("prbs9_head");
    for (int i = 0; i < 9; i++) check("period_511", 32'(rec0[i + 511]), 32'(rec0[i]));
    tick(); tick();
    check_quiet("after_cont");

    // Continuous, i_div=3: latency 5, period 4
    i_div = 4'd3;
    push_exp(6);
    i_enable = 1'b1;
    wait_valids(6, 4, 5, 1'b0);
    i_enable = 1'b0;
    tick();
    check_quiet("after_div3");
    check("symcnt_cont", 32'(o_sym_count), 32'(526));

    // Burst of 5 at i_div=1
    i_div = 4'd1; i_burst_mode = 1'b1; i_burst_len = 4'd5;
    push_exp(5);
    start_pulse();
    wait_valids(5, 2, 0, 1'b1);
    check("symcnt_burst5", 32'(o_sym_count), 32'(5));
    tick();
    check_quiet("after_burst5");

    // Burst length 0 means 16
    i_div = 4'd0; i_burst_len = 4'd0;
    push_exp(16);
    start_pulse();
    wait_valids(16, 1, 0, 1'b1);
    check("symcnt_burst16", 32'(o_sym_count), 32'(16));
    tick();
    check_quiet("after_burst16");

    // Channel 1 enabled mid-burst; mode/length changes inside the burst are ignored
    i_div = 4'd1; i_burst_len = 4'd14; i_ch_enable = 2'b01;
    push_exp(10);
    start_pulse();
    wait_valids(10, 2, 0, 1'b0);
    i_ch_enable = 2'b11; i_burst_len = 4'd3; i_burst_mode = 1'b0;
    push_exp(4);
    wait_valids(4, 2, 0, 1'b1);
    check("symcnt_burst14", 32'(o_sym_count), 32'(14));
    tick();
    check_quiet("after_burst14");

    // Abort mid-burst: no done
    i_burst_mode = 1'b1; i_burst_len = 4'd12; i_div = 4'd0;
    push_exp(5);
    start_pulse();
    wait_valids(5, 1, 0, 1'b0);
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("abort");
    end
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    // Reset while running continuously
    i_burst_mode = 1'b0;
    push_exp(5);
    i_enable = 1'b1;
    wait_valids(5, 1, 2, 1'b0);
    i_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_quiet("midreset");
      check("midreset_data", 32'(o_data), 32'(0));
      check("midreset_symcnt", 32'(o_sym_count), 32'(0));
    end
    i_enable = 1'b0;
    i_reset  = 1'b1;
    exp_q.delete();
    model_reset();
    rec0.delete();
    tick();
    check_quiet("post_reset");

    // LFSRs restart from their seeds
    i_ch_enable = 2'b11;
    push_exp(14);
    i_enable = 1'b1;
    wait_valids(14, 1, 2, 1'b0);
    i_enable = 1'b0;
    check_pattern("prbs9_after_reset");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
